// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime-loadable pattern (1..MAX_LEN bits), registered match pulse.
// Define SEQ_DET_COUNT_EN to add the saturating match_cnt output.
module seq_det_prog #(
  parameter int unsigned                MAX_LEN       = 8,
  parameter int unsigned                LEN_W         = $clog2(MAX_LEN + 1),
  parameter logic        [MAX_LEN-1:0]  RESET_PATTERN = 8'b0001_1011,
  parameter int unsigned                RESET_LEN     = 5,
  parameter bit                         RESET_OVERLAP = 1'b1,
  parameter int unsigned                CNT_W         = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               dout,
  output logic               busy
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RstLen = (RESET_LEN > MAX_LEN) ? MaxLen : LEN_W'(RESET_LEN);
  localparam state_e           RstState = (RstLen == '0) ? StIdle : StFill;

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  // The oldest history bit is shifted out before it could ever be compared, so it is not stored.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  state_e             state_q, state_d;
  logic               dout_q, dout_d;

  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_sat;
  logic [LEN_W-1:0]   cfg_len_clamped;
  logic               window_eq;
  logic               match;

  always_comb begin
    hist_next = {hist_q, din};
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    window_eq       = ((hist_next ^ pattern_q) & mask) == '0;
    fill_inc        = {1'b0, fill_q} + 1'b1;
    fill_sat        = (fill_inc >= {1'b0, len_q}) ? len_q : fill_inc[LEN_W-1:0];
    cfg_len_clamped = (cfg_len > MaxLen) ? MaxLen : cfg_len;
    match           = din_valid && !cfg_load && (state_q != StIdle) &&
                      (fill_inc >= {1'b0, len_q}) && window_eq;
  end

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    state_d   = state_q;
    dout_d    = 1'b0;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = cfg_len_clamped;
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
      state_d   = (cfg_len_clamped == '0) ? StIdle : StFill;
    end else if (din_valid && (state_q != StIdle)) begin
      hist_d = hist_next[MAX_LEN-2:0];
      dout_d = match;
      // Non-overlapping: the matched window is consumed, so refill from scratch.
      if (match && !overlap_q) begin
        fill_d  = '0;
        state_d = StFill;
      end else begin
        fill_d  = fill_sat;
        state_d = (fill_sat == len_q) ? StRun : StFill;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_q <= RESET_PATTERN;
      len_q     <= RstLen;
      overlap_q <= RESET_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      state_q   <= RstState;
      dout_q    <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      state_q   <= state_d;
      dout_q    <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != StIdle);

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: the driver queues expected outputs, a negedge monitor checks them.
module tb_seq_det_prog;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned CNT_W   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               dout;
  logic               busy;
`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0]   match_cnt;
`endif

  seq_det_prog #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .dout        (dout),
    .busy        (busy)
`ifdef SEQ_DET_COUNT_EN
    ,
    .match_cnt   (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef enum int {KDout, KBusy, KCnt} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  chk_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: every expectation queued by the driver on a rising edge is checked at the next falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t        c;
      logic [31:0] act;
      c = sb.pop_front();
      case (c.kind)
        KDout:   act = {31'd0, dout};
        KBusy:   act = {31'd0, busy};
`ifdef SEQ_DET_COUNT_EN
        KCnt:    act = 32'(match_cnt);
`endif
        default: act = 32'hdead_beef;
      endcase
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d at %0t", c.nm, act, c.exp, $time);
      end
    end
  end

  task automatic expect_val(input kind_e k, input logic [31:0] e, input string nm);
    chk_t c;
    c.kind = k;
    c.exp  = e;
    c.nm   = nm;
    sb.push_back(c);
  endtask

  task automatic step(input logic b, input logic v, input logic e, input string nm);
    din       = b;
    din_valid = v;
    cfg_load  = 1'b0;
    @(posedge clk);
    expect_val(KDout, {31'd0, e}, nm);
    #1;
  endtask

  // bits[n-1] is sent first; exp[n-1] is the expected dout after the first bit.
  task automatic send(input logic [31:0] bits, input logic [31:0] e, input int n, input string nm);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, e[i], $sformatf("%s[%0d]", nm, n - i));
    end
  endtask

  task automatic load(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                      input logic ov, input logic exp_busy, input string nm);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    cfg_load    = 1'b1;
    din         = 1'b1;
    din_valid   = 1'b1;
    @(posedge clk);
    expect_val(KDout, 32'd0, {nm, "_dout"});
    expect_val(KBusy, {31'd0, exp_busy}, {nm, "_busy"});
    #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic pulse_reset(input string nm);
    reset = 1'b1;
    @(posedge clk);
    expect_val(KDout, 32'd0, {nm, "_dout"});
    expect_val(KBusy, 32'd1, {nm, "_busy"});
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    @(posedge clk);
    expect_val(KDout, 32'd0, "rst_dout");
    expect_val(KBusy, 32'd1, "rst_busy");
`ifdef SEQ_DET_COUNT_EN
    expect_val(KCnt, 32'd0, "rst_cnt");
`endif
    #1;
    reset = 1'b0;

    // Legacy 11011 overlapping.
    send(32'b11011011, 32'b00001001, 8, "dflt_ovl");

    // 11011 non-overlapping.
    load(8'b0001_1011, 4'd5, 1'b0, 1'b1, "ld_nov");
    send(32'b11011011, 32'b00001000, 8, "nov_a");
    send(32'b11011, 32'b00001, 5, "nov_b");

    // 101 with and without overlap.
    load(8'b0000_0101, 4'd3, 1'b1, 1'b1, "ld_101o");
    send(32'b10101, 32'b00101, 5, "p101_ovl");
    load(8'b0000_0101, 4'd3, 1'b0, 1'b1, "ld_101n");
    send(32'b10101, 32'b00100, 5, "p101_nov");

    // Defaults restored by reset, invalid cycles (with garbage din) interleaved.
    pulse_reset("rst2");
    begin
      logic [4:0] s;
      logic [4:0] e;
      s = 5'b11011;
      e = 5'b00001;
      for (int i = 4; i >= 0; i--) begin
        step(s[i], 1'b1, e[i], $sformatf("gap_v%0d", 5 - i));
        step(~s[i], 1'b0, 1'b0, $sformatf("gap_i%0d", 5 - i));
      end
    end

    // Partial match lost by reset mid-stream.
    send(32'b1101, 32'b0000, 4, "pre_rst");
    pulse_reset("rst3");
    send(32'b1, 32'b0, 1, "post_rst");
    send(32'b1011, 32'b0001, 4, "post_rst_fill");

    // Length 0 disables the detector.
    load(8'b0001_1011, 4'd0, 1'b1, 1'b0, "ld_len0");
    send(32'b11011011, 32'b0, 8, "len0_a");
    send(32'b00000000, 32'b0, 8, "len0_b");
    @(posedge clk);
    expect_val(KBusy, 32'd0, "len0_busy");
    #1;

    // Length 12 clamps to 8.
    load(8'b1011_0011, 4'd12, 1'b1, 1'b1, "ld_len12");
    send(32'b10110011, 32'b00000001, 8, "len12_a");
    send(32'b10110011, 32'b00000001, 8, "len12_b");

`ifdef SEQ_DET_COUNT_EN
    load(8'b0000_0011, 4'd2, 1'b1, 1'b1, "ld_cnt");
    send(32'hFFFFF, 32'h7FFFF, 20, "cnt_ones");
    @(posedge clk);
    expect_val(KCnt, 32'd15, "cnt_sat");
    #1;
    load(8'b0000_0011, 4'd2, 1'b1, 1'b1, "ld_cnt2");
    @(posedge clk);
    expect_val(KCnt, 32'd0, "cnt_clr");
    #1;
`endif

    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
